// File: rtl/id_pkg.sv
// id_pkg: shared constants and types for the ID stage (field slices of the
// 32-bit instruction word, immediate-extension selector, decode bundle).
package id_pkg;

  localparam int XLEN_DEF = 32;
  localparam int IR_W     = 32;

  // Instruction field positions.
  localparam int OP_LSB   = 26;
  localparam int RS_LSB   = 21;
  localparam int RT_LSB   = 16;
  localparam int RD_LSB   = 11;
  localparam int SH_LSB   = 6;
  localparam int FIELD_W  = 5;
  localparam int IMM_W    = 16;
  localparam int JIDX_W   = 26;

  typedef enum logic {
    IMM_SEXT = 1'b0,
    IMM_ZEXT = 1'b1
  } imm_ext_e;

  // Decode bundle at the default datapath width.
  typedef struct packed {
    logic [XLEN_DEF-1:0] rd1;
    logic [XLEN_DEF-1:0] rd2;
    logic [XLEN_DEF-1:0] imm;
    logic [FIELD_W-1:0]  shamt;
    logic [FIELD_W-1:0]  wb_num;
    logic [XLEN_DEF-1:0] jaddr;
  } id_dec_t;

endpackage

// File: rtl/id_regfile.sv
// id_regfile: NREG x XLEN register file, two asynchronous read ports, one
// write port, register 0 hardwired to zero, cleared by asynchronous reset.
// Any write-first bypass is the parent's job.
module id_regfile
  import id_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int NREG   = 32,
  localparam int REG_AW = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] raddr1,
  input  logic [REG_AW-1:0] raddr2,
  output logic [XLEN-1:0]   rdata1,
  output logic [XLEN-1:0]   rdata2,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [XLEN-1:0]   wdata
);

  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];

  // Next register contents: apply the single write, never to register 0.
  always_comb begin
    regs_d = regs_q;
    if (we && (waddr != '0)) begin
      regs_d[waddr] = wdata;
    end
  end

  // Storage with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  assign rdata1 = (raddr1 == '0) ? '0 : regs_q[raddr1];
  assign rdata2 = (raddr2 == '0) ? '0 : regs_q[raddr2];

endmodule

// File: rtl/id_stage_pipe.sv
// id_stage_pipe: instruction decode with register-file read, held in a
// valid/ready ID/EX register; also owns HI/LO and the write-back port.
// Build option: define ID_WB_BYPASS_EN for write-first register reads at
// load time; otherwise reads are read-first.
module id_stage_pipe
  import id_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int NREG     = 32,
  parameter int LINK_REG = 31,
  parameter int SYS_R1   = 4,
  parameter int SYS_R2   = 2,
  localparam int REG_AW  = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IR_W-1:0]   in_ir,
  input  logic              syscall,
  input  logic              unsigned_imm,
  input  logic              reg_dst,
  input  logic              jr,
  input  logic              jal,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_rd1,
  output logic [XLEN-1:0]   out_rd2,
  output logic [XLEN-1:0]   out_imm,
  output logic [4:0]        out_shamt,
  output logic [REG_AW-1:0] out_wb_num,
  output logic [XLEN-1:0]   out_jaddr,
  input  logic              wb_en,
  input  logic [REG_AW-1:0] wb_num,
  input  logic [XLEN-1:0]   wb_data,
  input  logic              hi_we,
  input  logic [XLEN-1:0]   hi_data,
  input  logic              lo_we,
  input  logic [XLEN-1:0]   lo_data,
  output logic [XLEN-1:0]   hi,
  output logic [XLEN-1:0]   lo
);

  function automatic logic [XLEN-1:0] ext_imm(input logic [IMM_W-1:0] v,
                                              input imm_ext_e kind);
    if (kind == IMM_ZEXT) return {{(XLEN-IMM_W){1'b0}}, v};
    return {{(XLEN-IMM_W){v[IMM_W-1]}}, v};
  endfunction

  // Opcode bits are consumed by the main decoder, not here.
  logic unused_op;
  assign unused_op = ^in_ir[IR_W-1:OP_LSB];

  logic [REG_AW-1:0] r1_idx, r2_idx, wb_num_dec;
  logic [XLEN-1:0]   rf_rd1, rf_rd2, op1, op2, imm_dec, jaddr_dec;
  logic              wb_live;

  logic              valid_q, valid_d;
  logic [XLEN-1:0]   rd1_q, rd1_d, rd2_q, rd2_d, imm_q, imm_d, jaddr_q, jaddr_d;
  logic [4:0]        shamt_q, shamt_d;
  logic [REG_AW-1:0] wb_num_q, wb_num_d, r1_q, r1_d, r2_q, r2_d;
  logic              jr_q, jr_d;
  logic [XLEN-1:0]   hi_q, hi_d, lo_q, lo_d;

  logic load, stall;

  assign wb_live  = wb_en && (wb_num != '0);
  assign in_ready = !valid_q || out_ready;
  assign load     = in_valid && in_ready && !flush;
  assign stall    = valid_q && !out_ready;

  id_regfile #(.XLEN(XLEN), .NREG(NREG)) u_rf (
    .clk    (clk),
    .rst_n  (rst_n),
    .raddr1 (r1_idx),
    .raddr2 (r2_idx),
    .rdata1 (rf_rd1),
    .rdata2 (rf_rd2),
    .we     (wb_en),
    .waddr  (wb_num),
    .wdata  (wb_data)
  );

  // Field decode, operand selection and jump-target formation.
  always_comb begin
    r1_idx     = syscall ? REG_AW'(SYS_R1) : in_ir[RS_LSB +: REG_AW];
    r2_idx     = syscall ? REG_AW'(SYS_R2) : in_ir[RT_LSB +: REG_AW];
    wb_num_dec = jal     ? REG_AW'(LINK_REG)
               : (reg_dst ? in_ir[RD_LSB +: REG_AW] : in_ir[RT_LSB +: REG_AW]);
    imm_dec    = ext_imm(in_ir[IMM_W-1:0], imm_ext_e'(unsigned_imm));
`ifdef ID_WB_BYPASS_EN
    op1 = (wb_live && (wb_num == r1_idx)) ? wb_data : rf_rd1;
    op2 = (wb_live && (wb_num == r2_idx)) ? wb_data : rf_rd2;
`else
    op1 = rf_rd1;
    op2 = rf_rd2;
`endif
    jaddr_dec  = jr ? op1 : XLEN'(in_ir[JIDX_W-1:0]);
  end

  // ID/EX register next state: flush > load > pop; refresh held operands on stall.
  always_comb begin
    valid_d  = valid_q;
    rd1_d    = rd1_q;
    rd2_d    = rd2_q;
    imm_d    = imm_q;
    shamt_d  = shamt_q;
    wb_num_d = wb_num_q;
    jaddr_d  = jaddr_q;
    r1_d     = r1_q;
    r2_d     = r2_q;
    jr_d     = jr_q;
    hi_d     = hi_we ? hi_data : hi_q;
    lo_d     = lo_we ? lo_data : lo_q;

    if (flush) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end

    if (load) begin
      rd1_d    = op1;
      rd2_d    = op2;
      imm_d    = imm_dec;
      shamt_d  = in_ir[SH_LSB +: FIELD_W];
      wb_num_d = wb_num_dec;
      jaddr_d  = jaddr_dec;
      r1_d     = r1_idx;
      r2_d     = r2_idx;
      jr_d     = jr;
    end else if (stall && wb_live) begin
      // A stalled instruction must not carry a stale operand into EX.
      if (wb_num == r1_q) begin
        rd1_d = wb_data;
        if (jr_q) jaddr_d = wb_data;
      end
      if (wb_num == r2_q) begin
        rd2_d = wb_data;
      end
    end
  end

  // ---- ID/EX register and HI/LO state ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      rd1_q    <= '0;
      rd2_q    <= '0;
      imm_q    <= '0;
      shamt_q  <= '0;
      wb_num_q <= '0;
      jaddr_q  <= '0;
      r1_q     <= '0;
      r2_q     <= '0;
      jr_q     <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      valid_q  <= valid_d;
      rd1_q    <= rd1_d;
      rd2_q    <= rd2_d;
      imm_q    <= imm_d;
      shamt_q  <= shamt_d;
      wb_num_q <= wb_num_d;
      jaddr_q  <= jaddr_d;
      r1_q     <= r1_d;
      r2_q     <= r2_d;
      jr_q     <= jr_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign out_valid  = valid_q;
  assign out_rd1    = rd1_q;
  assign out_rd2    = rd2_q;
  assign out_imm    = imm_q;
  assign out_shamt  = shamt_q;
  assign out_wb_num = wb_num_q;
  assign out_jaddr  = jaddr_q;
  assign hi         = hi_q;
  assign lo         = lo_q;

endmodule

// File: tb/tb_id_stage_pipe.sv
// tb_id_stage_pipe: scoreboard bench for id_stage_pipe with a behavioural
// model (register array, HI/LO, one held instruction).
module tb_id_stage_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, syscall, unsigned_imm, reg_dst, jr, jal, flush;
  logic [31:0] in_ir;
  logic        out_valid, out_ready;
  logic [31:0] out_rd1, out_rd2, out_imm, out_jaddr;
  logic [4:0]  out_shamt, out_wb_num;
  logic        wb_en;
  logic [4:0]  wb_num;
  logic [31:0] wb_data;
  logic        hi_we, lo_we;
  logic [31:0] hi_data, lo_data, hi, lo;

  always #5 clk = ~clk;

  id_stage_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_ir(in_ir),
    .syscall(syscall), .unsigned_imm(unsigned_imm), .reg_dst(reg_dst), .jr(jr), .jal(jal),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_rd1(out_rd1), .out_rd2(out_rd2), .out_imm(out_imm), .out_shamt(out_shamt),
    .out_wb_num(out_wb_num), .out_jaddr(out_jaddr),
    .wb_en(wb_en), .wb_num(wb_num), .wb_data(wb_data),
    .hi_we(hi_we), .hi_data(hi_data), .lo_we(lo_we), .lo_data(lo_data), .hi(hi), .lo(lo)
  );

  typedef struct {
    logic [31:0] rd1, rd2, imm, jaddr;
    logic [4:0]  shamt, wb;
    int          r1, r2;
    bit          jr;
  } ent_t;

  logic [31:0] mregs [32];
  logic [31:0] mhi, mlo;
  bit          mvalid;
  ent_t        held;
  ent_t        exp_q[$];

  int n_vec = 0;
  int n_bad = 0;

`ifdef ID_WB_BYPASS_EN
  localparam logic [31:0] SAME_CYCLE_READ = 32'h1234;
`else
  localparam logic [31:0] SAME_CYCLE_READ = 32'h0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] rf_read(input int r);
    if (r == 0) return 32'h0;
`ifdef ID_WB_BYPASS_EN
    if (wb_en && (int'(wb_num) == r)) return wb_data;
`endif
    return mregs[r];
  endfunction

  // Model of one rising edge, from the spec's rules, using the inputs in force.
  task automatic model_edge();
    bit   rdy, ld, stl;
    ent_t e;
    if (!rst_n) return;
    rdy = !mvalid || out_ready;
    ld  = in_valid && rdy && !flush;
    stl = mvalid && !out_ready;
    e   = held;
    if (ld) begin
      e.r1    = syscall ? 4 : int'(in_ir[25:21]);
      e.r2    = syscall ? 2 : int'(in_ir[20:16]);
      e.jr    = jr;
      e.rd1   = rf_read(e.r1);
      e.rd2   = rf_read(e.r2);
      e.imm   = unsigned_imm ? {16'h0, in_ir[15:0]} : {{16{in_ir[15]}}, in_ir[15:0]};
      e.shamt = in_ir[10:6];
      e.wb    = jal ? 5'd31 : (reg_dst ? in_ir[15:11] : in_ir[20:16]);
      e.jaddr = jr ? e.rd1 : {6'h0, in_ir[25:0]};
    end
    if (stl && wb_en && wb_num != 5'd0) begin
      if (held.r1 == int'(wb_num)) begin
        held.rd1 = wb_data;
        if (held.jr) held.jaddr = wb_data;
      end
      if (held.r2 == int'(wb_num)) held.rd2 = wb_data;
    end
    if (flush) mvalid = 1'b0;
    else if (ld) begin mvalid = 1'b1; held = e; end
    else if (mvalid && out_ready) mvalid = 1'b0;
    if (wb_en && wb_num != 5'd0) mregs[wb_num] = wb_data;
    if (hi_we) mhi = hi_data;
    if (lo_we) mlo = lo_data;
  endtask

  // One clock: announce a handshake to the scoreboard, then advance the model.
  task automatic tick();
    if (rst_n && mvalid && out_ready) exp_q.push_back(held);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    in_valid = 0; in_ir = 0; syscall = 0; unsigned_imm = 0; reg_dst = 0; jr = 0; jal = 0;
    flush = 0; out_ready = 1; wb_en = 0; wb_num = 0; wb_data = 0;
    hi_we = 0; hi_data = 0; lo_we = 0; lo_data = 0;
  endtask

  task automatic model_reset();
    mvalid = 0; mhi = 0; mlo = 0;
    for (int i = 0; i < 32; i++) mregs[i] = 0;
    held = '{rd1: 0, rd2: 0, imm: 0, jaddr: 0, shamt: 0, wb: 0, r1: 0, r2: 0, jr: 0};
    exp_q.delete();
  endtask

  task automatic chk_zero_state(input string tag);
    chk({tag, " out_valid"}, 32'(out_valid), 32'h0);
    chk({tag, " out_rd1"}, out_rd1, 32'h0);
    chk({tag, " out_rd2"}, out_rd2, 32'h0);
    chk({tag, " out_imm"}, out_imm, 32'h0);
    chk({tag, " out_jaddr"}, out_jaddr, 32'h0);
    chk({tag, " out_wb_num"}, 32'(out_wb_num), 32'h0);
    chk({tag, " hi"}, hi, 32'h0);
    chk({tag, " lo"}, lo, 32'h0);
  endtask

  // Monitor: on every presented handshake pop the scoreboard and compare.
  always @(negedge clk) begin
    ent_t e;
    if (rst_n) begin
      chk("out_valid", 32'(out_valid), 32'(mvalid));
      chk("in_ready", 32'(in_ready), 32'(!mvalid || out_ready));
      chk("hi", hi, mhi);
      chk("lo", lo, mlo);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++; n_bad++;
          $display("FAIL pop: DUT presented an instruction, scoreboard empty at %0t", $time);
        end else begin
          e = exp_q.pop_front();
          chk("rd1", out_rd1, e.rd1);
          chk("rd2", out_rd2, e.rd2);
          chk("imm", out_imm, e.imm);
          chk("shamt", 32'(out_shamt), 32'(e.shamt));
          chk("wb_num", 32'(out_wb_num), 32'(e.wb));
          chk("jaddr", out_jaddr, e.jaddr);
        end
      end
    end
  end

  logic [31:0] rir;

  initial begin
    idle();
    rst_n = 0;
    model_reset();
    tick(); tick();
    chk_zero_state("reset");
    rst_n = 1;
    tick();

    // addi with negative immediate
    in_valid = 1; in_ir = 32'h2008FFFF;
    tick();
    idle();
    chk("t1 out_valid", 32'(out_valid), 32'h1);
    chk("t1 out_imm", out_imm, 32'hFFFFFFFF);
    chk("t1 out_wb_num", 32'(out_wb_num), 32'd8);
    tick();

    // write r5 while loading a read of r5
    wb_en = 1; wb_num = 5; wb_data = 32'h1234; in_valid = 1; in_ir = 32'h00A00000;
    tick();
    idle();
    chk("t2 same-cycle rd1", out_rd1, SAME_CYCLE_READ);
    tick();

    // stall holding rs=rt=7, then write r7
    in_valid = 1; in_ir = 32'h00E70000;
    tick();
    out_ready = 0;
    tick();
    chk("t3 in_ready stalled", 32'(in_ready), 32'h0);
    wb_en = 1; wb_num = 7; wb_data = 32'hAA;
    tick();
    wb_en = 0;
    chk("t3 refresh rd1", out_rd1, 32'hAA);
    chk("t3 refresh rd2", out_rd2, 32'hAA);
    chk("t3 in_ready held", 32'(in_ready), 32'h0);
    in_valid = 0; out_ready = 1;
    tick();

    // jal, then flush of the held instruction, then load+flush together
    in_valid = 1; jal = 1; reg_dst = 1; in_ir = 32'h0C000010;
    tick();
    idle();
    chk("t4 wb_num link", 32'(out_wb_num), 32'd31);
    chk("t4 jaddr", out_jaddr, 32'h10);
    out_ready = 0; flush = 1;
    tick();
    chk("t4 flushed held", 32'(out_valid), 32'h0);
    in_valid = 1; in_ir = 32'h2008FFFF; out_ready = 1;
    tick();
    idle();
    chk("t4 flushed incoming", 32'(out_valid), 32'h0);

    // syscall register overrides, and r0 stays zero
    wb_en = 1; wb_num = 4; wb_data = 3; tick();
    wb_num = 2; wb_data = 9; tick();
    wb_en = 0; in_valid = 1; syscall = 1; in_ir = 32'h03FF0000;
    tick();
    idle();
    chk("t5 sys rd1", out_rd1, 32'd3);
    chk("t5 sys rd2", out_rd2, 32'd9);
    wb_en = 1; wb_num = 0; wb_data = 32'hFFFF; tick();
    idle(); in_valid = 1; in_ir = 32'h0;
    tick();
    idle();
    chk("t5 r0 reads zero", out_rd1, 32'h0);

    // HI/LO together, then reset in the middle of a stall
    hi_we = 1; hi_data = 1; lo_we = 1; lo_data = 2;
    tick();
    idle();
    chk("t6 hi", hi, 32'h1);
    chk("t6 lo", lo, 32'h2);
    in_valid = 1; in_ir = 32'h00E70000; tick();
    out_ready = 0; tick();
    #2;
    rst_n = 0;
    model_reset();
    #1;
    chk_zero_state("midstall reset");
    tick();
    idle();
    rst_n = 1;
    tick();
    in_valid = 1; in_ir = 32'h00E70000;
    tick();
    idle();
    chk("t6 regs cleared", out_rd1, 32'h0);

    // randomized traffic with frequent register collisions
    for (int k = 0; k < 600; k++) begin
      rir = $urandom;
      rir[25:21] = 5'($urandom_range(0, 7));
      rir[20:16] = 5'($urandom_range(0, 7));
      in_ir        = rir;
      in_valid     = ($urandom_range(0, 9) < 7);
      out_ready    = ($urandom_range(0, 9) < 6);
      flush        = ($urandom_range(0, 9) == 0);
      syscall      = ($urandom_range(0, 9) == 0);
      unsigned_imm = $urandom_range(0, 1) == 1;
      reg_dst      = $urandom_range(0, 1) == 1;
      jr           = ($urandom_range(0, 3) == 0);
      jal          = ($urandom_range(0, 5) == 0);
      wb_en        = $urandom_range(0, 1) == 1;
      wb_num       = 5'($urandom_range(0, 7));
      wb_data      = $urandom;
      hi_we        = ($urandom_range(0, 3) == 0);
      hi_data      = $urandom;
      lo_we        = ($urandom_range(0, 3) == 0);
      lo_data      = $urandom;
      tick();
    end

    idle();
    tick(); tick(); tick();
    n_vec++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expected entries left, expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
